// File: rtl/dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dma_timing_ctrl : one-hot DMA bus-cycle sequencer (SI/S0/S1/S2/S3/SW/S4)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_timing_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int STATEWIDTH = 7
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  dreqActive,
  input  logic [CHANNELS-1:0]   grant,
  input  logic                  HLDA,
  input  logic                  READY,
  input  logic                  EOP_N_in,
  input  logic                  tcReached,
  input  logic                  upperChange,
  input  logic [1:0]            mode,
  input  logic [1:0]            xferType,
  input  logic                  compressed,
  input  logic                  extWrite,
  output logic                  HRQ,
  output logic                  AEN,
  output logic                  ADSTB,
  output logic [CHANNELS-1:0]   DACK,
  output logic                  MEMR_N,
  output logic                  MEMW_N,
  output logic                  IOR_N,
  output logic                  IOW_N,
  output logic                  eopDrive,
  output logic                  update,
  output logic [STATEWIDTH-1:0] state,
  output logic [STATEWIDTH-1:0] nextState
);

  localparam int B_SI = 0;
  localparam int B_S0 = 1;
  localparam int B_S1 = 2;
  localparam int B_S2 = 3;
  localparam int B_S3 = 4;
  localparam int B_SW = 5;
  localparam int B_S4 = 6;

  localparam logic [STATEWIDTH-1:0] ST_SI = STATEWIDTH'(1) << B_SI;
  localparam logic [STATEWIDTH-1:0] ST_S0 = STATEWIDTH'(1) << B_S0;
  localparam logic [STATEWIDTH-1:0] ST_S1 = STATEWIDTH'(1) << B_S1;
  localparam logic [STATEWIDTH-1:0] ST_S2 = STATEWIDTH'(1) << B_S2;
  localparam logic [STATEWIDTH-1:0] ST_S3 = STATEWIDTH'(1) << B_S3;
  localparam logic [STATEWIDTH-1:0] ST_SW = STATEWIDTH'(1) << B_SW;
  localparam logic [STATEWIDTH-1:0] ST_S4 = STATEWIDTH'(1) << B_S4;

  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;
  localparam logic [1:0] XFER_WRITE  = 2'b01;
  localparam logic [1:0] XFER_READ   = 2'b10;

  logic [STATEWIDTH-1:0] state_q;
  logic [STATEWIDTH-1:0] state_d;
  logic                  in_xfer;
  logic                  read_phase;
  logic                  write_phase;
  logic                  is_read;
  logic                  is_write;
  logic [STATEWIDTH-1:0] cont_state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_SI;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_xfer    = state_q[B_S1] | state_q[B_S2] | state_q[B_S3] |
                      state_q[B_SW] | state_q[B_S4];
  // Block/demand continuation re-strobes the upper address only when it changes.
  assign cont_state = upperChange ? ST_S1 : ST_S2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SI: if (dreqActive) state_d = ST_S0;
      ST_S0: begin
        if (HLDA)             state_d = ST_S1;
        else if (!dreqActive) state_d = ST_SI;
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = compressed ? ST_S4 : ST_S3;
      ST_S3: state_d = READY ? ST_S4 : ST_SW;
      ST_SW: state_d = READY ? ST_S4 : ST_SW;
      ST_S4: begin
        if (tcReached) begin
          state_d = ST_SI;
        end else begin
          case (mode)
            MODE_BLOCK:  state_d = cont_state;
            MODE_DEMAND: state_d = dreqActive ? cont_state : ST_SI;
            default:     state_d = ST_SI;
          endcase
        end
      end
      default: state_d = ST_SI;
    endcase
    // Aborts override every normal transition.
    if (!HLDA && in_xfer) state_d = ST_SI;
    if (!EOP_N_in)        state_d = ST_SI;
  end

  assign is_read     = (xferType == XFER_READ);
  assign is_write    = (xferType == XFER_WRITE);
  assign read_phase  = state_q[B_S2] | state_q[B_S3] | state_q[B_SW] | state_q[B_S4];
  assign write_phase = state_q[B_S3] | state_q[B_SW] | state_q[B_S4] |
                       (state_q[B_S2] & extWrite);

  always_comb begin
    HRQ      = !state_q[B_SI];
    AEN      = in_xfer;
    ADSTB    = state_q[B_S1];
    DACK     = in_xfer ? grant : '0;
    MEMR_N   = !(read_phase  && is_read);
    IOR_N    = !(read_phase  && is_write);
    MEMW_N   = !(write_phase && is_write);
    IOW_N    = !(write_phase && is_read);
    update   = state_q[B_S4];
    eopDrive = state_q[B_S4] && tcReached;
  end

  assign state     = state_q;
  assign nextState = state_d;

endmodule

`default_nettype wire

// File: tb/tb_dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_timing_ctrl : directed scoreboard bench for dma_timing_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dma_timing_ctrl;

  localparam int CH = 4;
  localparam logic [6:0] SI = 7'b0000001;
  localparam logic [6:0] S0 = 7'b0000010;
  localparam logic [6:0] S1 = 7'b0000100;
  localparam logic [6:0] S2 = 7'b0001000;
  localparam logic [6:0] S3 = 7'b0010000;
  localparam logic [6:0] SW = 7'b0100000;
  localparam logic [6:0] S4 = 7'b1000000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          dreqActive, HLDA, READY, EOP_N_in, tcReached, upperChange;
  logic          compressed, extWrite;
  logic [1:0]    mode, xferType;
  logic [CH-1:0] grant;
  logic          HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, eopDrive, update;
  logic [CH-1:0] DACK;
  logic [6:0]    state, nextState;

  logic [6:0] sb_q[$];
  int checks  = 0;
  int errors  = 0;
  int upd_cnt = 0;
  int eop_cnt = 0;

  always #5 CLK = ~CLK;

  dma_timing_ctrl #(.CHANNELS(CH), .STATEWIDTH(7)) dut (
    .CLK(CLK), .RESET(RESET), .dreqActive(dreqActive), .grant(grant), .HLDA(HLDA),
    .READY(READY), .EOP_N_in(EOP_N_in), .tcReached(tcReached), .upperChange(upperChange),
    .mode(mode), .xferType(xferType), .compressed(compressed), .extWrite(extWrite),
    .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .eopDrive(eopDrive), .update(update),
    .state(state), .nextState(nextState)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected Moore outputs for a given state under the current inputs.
  task automatic check_outputs(input logic [6:0] st);
    logic act, rd, wr;
    act = |st[6:2];
    rd  = |st[6:3];
    wr  = (|st[6:4]) | (st[3] & extWrite);
    chk("HRQ",      {31'd0, HRQ},      {31'd0, !st[0]});
    chk("AEN",      {31'd0, AEN},      {31'd0, act});
    chk("ADSTB",    {31'd0, ADSTB},    {31'd0, st[2]});
    chk("DACK",     {28'd0, DACK},     {28'd0, (act ? grant : 4'b0000)});
    chk("MEMR_N",   {31'd0, MEMR_N},   {31'd0, !(rd && xferType == 2'b10)});
    chk("IOR_N",    {31'd0, IOR_N},    {31'd0, !(rd && xferType == 2'b01)});
    chk("MEMW_N",   {31'd0, MEMW_N},   {31'd0, !(wr && xferType == 2'b01)});
    chk("IOW_N",    {31'd0, IOW_N},    {31'd0, !(wr && xferType == 2'b10)});
    chk("update",   {31'd0, update},   {31'd0, st[6]});
    chk("eopDrive", {31'd0, eopDrive}, {31'd0, st[6] & tcReached});
  endtask

  task automatic tick();
    logic [6:0] exp_st;
    @(posedge CLK);
    #1;
    chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      exp_st = sb_q.pop_front();
      chk("state", {25'd0, state}, {25'd0, exp_st});
      check_outputs(exp_st);
    end
    if (update)   upd_cnt++;
    if (eopDrive) eop_cnt++;
  endtask

  task automatic go(input logic [6:0] st);
    sb_q.push_back(st);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; dreqActive = 1'b0; HLDA = 1'b0; READY = 1'b1; EOP_N_in = 1'b1;
    tcReached = 1'b0; upperChange = 1'b0; compressed = 1'b0; extWrite = 1'b0;
    mode = 2'b01; xferType = 2'b10; grant = 4'b0100;

    #12;
    chk("reset_state", {25'd0, state}, {25'd0, SI});
    check_outputs(SI);
    RESET = 1'b0;
    sb_q.push_back(SI);
    tick();

    // Single read, normal timing, HLDA arrives in second S0 cycle
    upd_cnt = 0;
    dreqActive = 1'b1;
    go(S0);
    go(S0);
    HLDA = 1'b1;
    go(S1); go(S2); go(S3);
    dreqActive = 1'b0;
    go(S4); go(SI);
    chk("single_updates", upd_cnt, 1);

    // Write with READY wait states
    upd_cnt = 0; xferType = 2'b01; dreqActive = 1'b1;
    go(S0); go(S1); go(S2);
    READY = 1'b0;
    go(S3); go(SW); go(SW);
    READY = 1'b1;
    go(S4);
    dreqActive = 1'b0;
    go(SI);
    chk("wait_updates", upd_cnt, 1);

    // Block, compressed timing, four words
    upd_cnt = 0; eop_cnt = 0; mode = 2'b10; compressed = 1'b1; xferType = 2'b10;
    dreqActive = 1'b1;
    go(S0); go(S1); go(S2);
    go(S4); go(S2); go(S4); go(S2); go(S4); go(S2);
    tcReached = 1'b1;
    go(S4);
    dreqActive = 1'b0;
    go(SI);
    tcReached = 1'b0;
    chk("block_updates", upd_cnt, 4);
    chk("block_eops", eop_cnt, 1);

    // External EOP abort in S2 of a block transfer
    upd_cnt = 0; compressed = 1'b0; extWrite = 1'b1; dreqActive = 1'b1;
    go(S0); go(S1); go(S2);
    EOP_N_in = 1'b0;
    go(SI);
    go(SI);
    chk("next_eop_hold", {25'd0, nextState}, {25'd0, SI});
    EOP_N_in = 1'b1;
    #1 chk("next_si_req", {25'd0, nextState}, {25'd0, S0});
    dreqActive = 1'b0;
    #1 chk("next_si_idle", {25'd0, nextState}, {25'd0, SI});
    chk("eop_abort_updates", upd_cnt, 0);
    extWrite = 1'b0;

    // HLDA drop in S3
    upd_cnt = 0; mode = 2'b01; dreqActive = 1'b1;
    go(S0); go(S1); go(S2); go(S3);
    HLDA = 1'b0;
    go(SI);
    dreqActive = 1'b0;
    HLDA = 1'b1;
    chk("hlda_abort_updates", upd_cnt, 0);

    // Demand mode: continue with upper change, then requester falls before S4
    upd_cnt = 0; mode = 2'b00; xferType = 2'b01; upperChange = 1'b1; dreqActive = 1'b1;
    go(S0); go(S1); go(S2); go(S3); go(S4);
    go(S1);
    upperChange = 1'b0;
    go(S2); go(S3);
    dreqActive = 1'b0;
    go(S4); go(SI);
    chk("demand_updates", upd_cnt, 2);

    // Async reset while in SW
    mode = 2'b01; xferType = 2'b10; dreqActive = 1'b1;
    go(S0); go(S1); go(S2);
    READY = 1'b0;
    go(S3); go(SW);
    dreqActive = 1'b0;
    #3 RESET = 1'b1;
    #1;
    chk("async_reset_state", {25'd0, state}, {25'd0, SI});
    check_outputs(SI);
    #2 RESET = 1'b0;
    READY = 1'b1;
    go(SI);

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
